spi_slave_byte: RTL and testbench

//  SPI slave (target) for frames produced by the team's byte-wide SPI master.

---
 rtl/spi_slave_byte_pkg.sv | 39 +++
 rtl/spi_slave_byte_if.sv | 34 +++
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/spi_slave_byte.sv | 159 +++++++++++++++
 tb/tb_spi_slave_byte.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_byte_pkg.sv
// Shared types, SPI mode constants and sclk edge decoding for spi_slave_byte.
// Contents:
//   byte_t       8-bit data byte
//   sclk_evt_t   per-clock sample/shift strobes derived from sclk edges
//   sclk_events  maps raw sclk rise/fall to sample/shift for a CPOL/CPHA mode
package spi_slave_byte_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  // SPI mode constants, common with spi_master_byte.
  localparam bit CPOL_IDLE_LOW     = 1'b0;
  localparam bit CPOL_IDLE_HIGH    = 1'b1;
  localparam bit CPHA_LEAD_SAMPLE  = 1'b0;
  localparam bit CPHA_TRAIL_SAMPLE = 1'b1;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t FILL_BYTE_DEFAULT = 8'hFF;

  typedef struct packed {
    logic sample;
    logic shift;
  } sclk_evt_t;

  // Leading edge leaves the idle level; CPHA picks which edge samples.
  function automatic sclk_evt_t sclk_events(input bit cpol, input bit cpha,
                                            input logic rise, input logic fall);
    sclk_evt_t e;
    logic lead;
    logic trail;
    lead     = cpol ? fall : rise;
    trail    = cpol ? rise : fall;
    e.sample = cpha ? trail : lead;
    e.shift  = cpha ? lead : trail;
    return e;
  endfunction

endpackage

// File: rtl/spi_slave_byte_if.sv
// Pin and FIFO bundle of spi_slave_byte.
//   SPI side : sclk, n_cs, mosi (to slave), miso, miso_oe (from slave)
//   TX FIFO  : empty, data_i (show-ahead) in, rdreq out
//   RX FIFO  : full in, data_o, wrreq out
//   Status   : busy, overrun (sticky), underrun (pulse)
interface spi_slave_byte_if;
  import spi_slave_byte_pkg::*;

  logic  sclk;
  logic  n_cs;
  logic  mosi;
  logic  miso;
  logic  miso_oe;
  logic  empty;
  byte_t data_i;
  logic  rdreq;
  logic  full;
  byte_t data_o;
  logic  wrreq;
  logic  busy;
  logic  overrun;
  logic  underrun;

  modport slave (
    input  sclk, n_cs, mosi, empty, data_i, full,
    output miso, miso_oe, rdreq, data_o, wrreq, busy, overrun, underrun
  );

  modport master (
    output sclk, n_cs, mosi, empty, data_i, full,
    input  miso, miso_oe, rdreq, data_o, wrreq, busy, overrun, underrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus history flop with edge detection.
//   clk, rst  system clock, async active-high reset
//   d         asynchronous input
//   sync      synchronised level
//   rise_c    sync went 0->1 this cycle (combinational)
//   fall_c    sync went 1->0 this cycle (combinational)
module spi_sync_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;
  logic hist_d, hist_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sync   = sync_q;
  assign rise_c = sync_q & ~hist_q;
  assign fall_c = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI slave: oversamples sclk/n_cs/mosi on clk, deserialises MOSI bytes into
// the RX FIFO and serialises MISO bytes from a show-ahead TX FIFO.
//   clk, rst  system clock, async active-high reset
//   bus       spi_slave_byte_if.slave (SPI pins, TX/RX FIFO ports, status)
// Parameters: CPOL (sclk idle level), CPHA (0: sample leading edge),
//             FILL_BYTE (sent when the TX FIFO is empty at a byte boundary).
module spi_slave_byte
  import spi_slave_byte_pkg::*;
#(
  parameter bit    CPOL      = CPOL_IDLE_LOW,
  parameter bit    CPHA      = CPHA_LEAD_SAMPLE,
  parameter byte_t FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_byte_if.slave bus
);

  localparam int unsigned RX_SR_W = BYTE_W - 1;

  logic sclk_sync, sclk_rise_c, sclk_fall_c;
  logic ncs_sync, ncs_rise_c, ncs_fall_c;
  logic mosi_sync, mosi_rise_c, mosi_fall_c;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(bus.sclk),
    .sync(sclk_sync), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(bus.n_cs),
    .sync(ncs_sync), .rise_c(ncs_rise_c), .fall_c(ncs_fall_c)
  );

  // mosi is delayed exactly like sclk so it is sampled on the matching edge.
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(bus.mosi),
    .sync(mosi_sync), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_sync, ncs_rise_c, mosi_rise_c, mosi_fall_c};

  sclk_evt_t evt_c;
  logic      active_c;
  assign evt_c    = sclk_events(CPOL, CPHA, sclk_rise_c, sclk_fall_c);
  assign active_c = ~ncs_sync;

  // Only the low 7 bits of the byte in flight need storing; bit 0 arrives live.
  logic [RX_SR_W-1:0] rx_sr_d, rx_sr_q;
  logic [CNT_W-1:0]   bit_cnt_d, bit_cnt_q;
  byte_t              tx_sr_d, tx_sr_q;
  logic               tx_pend_d, tx_pend_q;
  logic               tx_fill_d, tx_fill_q;
  byte_t              data_o_d, data_o_q;
  logic               wrreq_d, wrreq_q;
  logic               rdreq_d, rdreq_q;
  logic               overrun_d, overrun_q;
  logic               underrun_d, underrun_q;
  logic               busy_d, busy_q;
  logic               miso_oe_d, miso_oe_q;
  byte_t              rx_byte_c;
  logic               load_c;

  // Byte engine. A TX load only peeks the show-ahead FIFO; the pop (or the
  // underrun report) is deferred to the first sample of that byte, so the
  // speculative load after the last byte of a frame consumes nothing.
  always_comb begin
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    tx_pend_d  = tx_pend_q;
    tx_fill_d  = tx_fill_q;
    data_o_d   = data_o_q;
    wrreq_d    = 1'b0;
    rdreq_d    = 1'b0;
    overrun_d  = overrun_q;
    underrun_d = 1'b0;
    busy_d     = active_c;
    miso_oe_d  = active_c;
    rx_byte_c  = {rx_sr_q, mosi_sync};
    load_c     = 1'b0;

    if (!active_c) begin
      bit_cnt_d = '0;
      tx_pend_d = 1'b0;
    end else if (ncs_fall_c) begin
      // A coincident sclk edge is ignored; the master guarantees setup.
      bit_cnt_d = '0;
      load_c    = ~CPHA;
    end else begin
      if (evt_c.sample) begin
        rx_sr_d   = rx_byte_c[RX_SR_W-1:0];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == '0 && tx_pend_q) begin
          tx_pend_d  = 1'b0;
          rdreq_d    = ~tx_fill_q;
          underrun_d = tx_fill_q;
        end
        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
          data_o_d = rx_byte_c;
          if (bus.full) overrun_d = 1'b1;
          else          wrreq_d   = 1'b1;
        end
      end
      if (evt_c.shift) begin
        // CPHA=0: trailing edge after the 8th sample; CPHA=1: first leading edge.
        if (bit_cnt_q == '0) load_c  = 1'b1;
        else                 tx_sr_d = tx_sr_q << 1;
      end
    end

    if (load_c) begin
      tx_pend_d = 1'b1;
      tx_fill_d = bus.empty;
      tx_sr_d   = bus.empty ? FILL_BYTE : bus.data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      tx_pend_q  <= 1'b0;
      tx_fill_q  <= 1'b0;
      data_o_q   <= '0;
      wrreq_q    <= 1'b0;
      rdreq_q    <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      tx_pend_q  <= tx_pend_d;
      tx_fill_q  <= tx_fill_d;
      data_o_q   <= data_o_d;
      wrreq_q    <= wrreq_d;
      rdreq_q    <= rdreq_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      miso_oe_q  <= miso_oe_d;
    end
  end

  assign bus.miso     = tx_sr_q[BYTE_W-1];
  assign bus.miso_oe  = miso_oe_q;
  assign bus.rdreq    = rdreq_q;
  assign bus.data_o   = data_o_q;
  assign bus.wrreq    = wrreq_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: one DUT per CPOL/CPHA mode, a bit-banged master,
// a TX FIFO model and scoreboards for MOSI->data_o and TX FIFO->MISO bytes.
module tb_spi_slave_byte;
  import spi_slave_byte_pkg::*;

  localparam int H = 4;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk_v, ncs_v, mosi_v;
  logic [3:0] miso_v, oe_v, rdreq_v, wrreq_v, busy_v, ovr_v, ur_v;
  byte_t      data_o_a [4];
  logic       empty, full;
  byte_t      data_i;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_byte_if bus ();
    assign bus.sclk   = sclk_v[g];
    assign bus.n_cs   = ncs_v[g];
    assign bus.mosi   = mosi_v[g];
    assign bus.empty  = empty;
    assign bus.data_i = data_i;
    assign bus.full   = full;
    assign miso_v[g]   = bus.miso;
    assign oe_v[g]     = bus.miso_oe;
    assign rdreq_v[g]  = bus.rdreq;
    assign wrreq_v[g]  = bus.wrreq;
    assign busy_v[g]   = bus.busy;
    assign ovr_v[g]    = bus.overrun;
    assign ur_v[g]     = bus.underrun;
    assign data_o_a[g] = bus.data_o;
    spi_slave_byte #(.CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .FILL_BYTE(8'hFF)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
  end

  int    n_chk = 0;
  int    n_pass = 0;
  int    cur = 0;
  int    rd_cnt = 0, ur_cnt = 0, wr_cnt = 0;
  byte_t tx_q[$];
  byte_t rx_exp[$];
  byte_t mi_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // FIFO model and RX scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    byte_t popped;
    byte_t e;
    if (!rst) begin
      if (|rdreq_v) begin
        rd_cnt++;
        if (tx_q.size() > 0) popped = tx_q.pop_front();
        else check("rdreq_on_empty", 32'd1, 32'd0);
      end
      if (|ur_v) ur_cnt++;
      if (wrreq_v[cur]) begin
        wr_cnt++;
        if (rx_exp.size() == 0) check("wrreq_unexpected", 32'(data_o_a[cur]), 32'hFFFF_FFFF);
        else begin
          e = rx_exp.pop_front();
          check("rx_byte", 32'(data_o_a[cur]), 32'(e));
        end
      end
    end
    empty  = (tx_q.size() == 0);
    data_i = (tx_q.size() == 0) ? 8'h00 : tx_q[0];
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit m_cpol(); return (cur / 2) == 1; endfunction
  function automatic bit m_cpha(); return (cur % 2) == 1; endfunction

  task automatic cs_low();
    ncs_v[cur] = 1'b0;
    wait_clk(m_cpha() ? H : H - 2);
  endtask

  task automatic cs_high();
    wait_clk(H);
    ncs_v[cur] = 1'b1;
    wait_clk(3 * H);
  endtask

  // Bit-banged master: shifts nbits of mo out MSB first, returns MISO bits.
  task automatic xfer(input byte_t mo, input int nbits, output byte_t mi);
    bit cpol, cpha;
    cpol = m_cpol();
    cpha = m_cpha();
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_v[cur] = mo[3'(7 - i)];
        wait_clk(2);
        mi = {mi[6:0], miso_v[cur]};
      end else begin
        mosi_v[cur] = mo[3'(7 - i)];
      end
      sclk_v[cur] = ~cpol;
      wait_clk(H);
      if (cpha) mi = {mi[6:0], miso_v[cur]};
      sclk_v[cur] = cpol;
      wait_clk(cpha ? H : H - 2);
    end
  endtask

  task automatic send_byte(input byte_t mo, input byte_t mi_e, input bit expect_wr);
    byte_t got, e;
    if (expect_wr) rx_exp.push_back(mo);
    mi_exp.push_back(mi_e);
    xfer(mo, 8, got);
    e = mi_exp.pop_front();
    check("miso_byte", 32'(got), 32'(e));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     32'(miso_v[cur]),   32'd0);
    check({tag, "_miso_oe"},  32'(oe_v[cur]),     32'd0);
    check({tag, "_rdreq"},    32'(rdreq_v[cur]),  32'd0);
    check({tag, "_wrreq"},    32'(wrreq_v[cur]),  32'd0);
    check({tag, "_data_o"},   32'(data_o_a[cur]), 32'd0);
    check({tag, "_busy"},     32'(busy_v[cur]),   32'd0);
    check({tag, "_overrun"},  32'(ovr_v[cur]),    32'd0);
    check({tag, "_underrun"}, 32'(ur_v[cur]),     32'd0);
  endtask

  typedef struct {
    int    mode;
    byte_t mo0, mo1;
    byte_t tx0, tx1;
    int    exp_rd;
    int    exp_ur;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    byte_t got;
    vecs[0] = '{0, 8'hA5, 8'h3C, 8'h81, 8'h7E, 2, 0};
    vecs[1] = '{0, 8'hC3, 8'h5A, 8'h5A, 8'hC3, 2, 0};
    vecs[2] = '{1, 8'hC3, 8'h5A, 8'h5A, 8'hC3, 2, 0};
    vecs[3] = '{2, 8'hC3, 8'h5A, 8'h5A, 8'hC3, 2, 0};
    vecs[4] = '{3, 8'hC3, 8'h5A, 8'h5A, 8'hC3, 2, 0};

    rst    = 1'b1;
    sclk_v = 4'b1100;
    ncs_v  = 4'hF;
    mosi_v = 4'h0;
    full   = 1'b0;
    empty  = 1'b1;
    data_i = 8'h00;
    #1;
    for (int m = 0; m < 4; m++) begin
      cur = m;
      check_reset_outputs("reset");
    end
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);

    // Two-byte frames in every mode.
    foreach (vecs[v]) begin
      cur = vecs[v].mode;
      rd_cnt = 0; ur_cnt = 0;
      tx_q.push_back(vecs[v].tx0);
      tx_q.push_back(vecs[v].tx1);
      wait_clk(2);
      cs_low();
      send_byte(vecs[v].mo0, vecs[v].tx0, 1'b1);
      check("busy_in_frame", 32'(busy_v[cur]), 32'd1);
      check("oe_in_frame",   32'(oe_v[cur]),   32'd1);
      send_byte(vecs[v].mo1, vecs[v].tx1, 1'b1);
      cs_high();
      check("rdreq_count",    32'(rd_cnt), 32'(vecs[v].exp_rd));
      check("underrun_count", 32'(ur_cnt), 32'(vecs[v].exp_ur));
      check("rx_drained",     32'(rx_exp.size()), 32'd0);
      check("busy_idle",      32'(busy_v[cur]), 32'd0);
      check("oe_idle",        32'(oe_v[cur]),   32'd0);
    end

    // Empty TX FIFO: fill byte, one underrun, no reads.
    cur = 0; rd_cnt = 0; ur_cnt = 0;
    cs_low();
    send_byte(8'h00, 8'hFF, 1'b1);
    cs_high();
    check("empty_underrun", 32'(ur_cnt), 32'd1);
    check("empty_rdreq",    32'(rd_cnt), 32'd0);
    check("empty_rx",       32'(rx_exp.size()), 32'd0);

    // Frame aborted after 5 bits, then a clean frame.
    rd_cnt = 0; wr_cnt = 0;
    tx_q.push_back(8'h11);
    wait_clk(2);
    cs_low();
    xfer(8'hF0, 5, got);
    cs_high();
    check("abort_no_write", 32'(wr_cnt), 32'd0);
    check("abort_bit_cnt",  32'(g_dut[0].u_dut.bit_cnt_q), 32'd0);
    tx_q.push_back(8'h24);
    wait_clk(2);
    cs_low();
    send_byte(8'h0F, 8'h24, 1'b1);
    cs_high();
    check("abort_next_rx", 32'(wr_cnt), 32'd1);
    check("abort_rdreq",   32'(rd_cnt), 32'd2);

    // RX FIFO full during the second byte.
    wr_cnt = 0;
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h02);
    wait_clk(2);
    cs_low();
    send_byte(8'h11, 8'h01, 1'b1);
    full = 1'b1;
    send_byte(8'h22, 8'h02, 1'b0);
    cs_high();
    full = 1'b0;
    check("full_one_write", 32'(wr_cnt), 32'd1);
    check("overrun_set",    32'(ovr_v[cur]), 32'd1);
    tx_q.push_back(8'h03);
    wait_clk(2);
    cs_low();
    send_byte(8'h33, 8'h03, 1'b1);
    cs_high();
    check("overrun_sticky", 32'(ovr_v[cur]), 32'd1);

    // Reset in the middle of a byte.
    tx_q.push_back(8'h96);
    wait_clk(2);
    cs_low();
    xfer(8'h77, 4, got);
    wait_clk(1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    ncs_v[cur] = 1'b1;
    tx_q.delete();
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    wr_cnt = 0;
    tx_q.push_back(8'hA1);
    wait_clk(2);
    cs_low();
    send_byte(8'h5C, 8'hA1, 1'b1);
    cs_high();
    check("post_rst_write", 32'(wr_cnt), 32'd1);
    check("post_rst_rx",    32'(rx_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
